// File: rtl/mem_access_arbiter.sv
// Two-master access controller for the 16x8 data RAM and 1024x20 command memory.
// Ports: m0_*/m1_* master request/response, ram_*/cmd_* memory side, busy status.
module mem_access_arbiter #(
   parameter int RAM_W       = 8,
   parameter int CMD_W       = 20,
   parameter int RAM_AW      = 4,
   parameter int CMD_AW      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic              m0_we,
   input  logic              m1_we,
   input  logic              m0_sel,
   input  logic              m1_sel,
   input  logic [CMD_AW-1:0] m0_addr,
   input  logic [CMD_AW-1:0] m1_addr,
   input  logic [CMD_W-1:0]  m0_wdata,
   input  logic [CMD_W-1:0]  m1_wdata,
   output logic              m0_ack,
   output logic              m1_ack,
   output logic              m0_err,
   output logic              m1_err,
   output logic [CMD_W-1:0]  m0_rdata,
   output logic [CMD_W-1:0]  m1_rdata,
   output logic              ram_en,
   output logic              ram_rw,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [RAM_W-1:0]  ram_wdata,
   input  logic [RAM_W-1:0]  ram_rdata,
   output logic              cmd_en,
   output logic              cmd_rw,
   output logic [CMD_AW-1:0] cmd_addr,
   output logic [CMD_W-1:0]  cmd_wdata,
   input  logic [CMD_W-1:0]  cmd_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

   state_t            state, state_nxt;
   logic              last_q, last_nxt;
   logic              gnt_q, gnt_nxt;
   logic              we_q, we_nxt;
   logic              sel_q, sel_nxt;
   logic              err_q, err_nxt;
   logic [CMD_AW-1:0] addr_q, addr_nxt;
   logic [CMD_W-1:0]  wdata_q, wdata_nxt;
   logic [2:0]        cnt_q, cnt_nxt;
   logic              cap;
   logic              act, rw_d, ram_act, cmd_act;
   logic [CMD_W-1:0]  ram_ext;

   assign busy    = (state != IDLE);
   assign ram_ext = {{(CMD_W-RAM_W){1'b0}}, ram_rdata};

   always_comb begin
      state_nxt = state;
      last_nxt  = last_q;
      gnt_nxt   = gnt_q;
      we_nxt    = we_q;
      sel_nxt   = sel_q;
      err_nxt   = err_q;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      cnt_nxt   = cnt_q;
      cap       = 1'b0;
      unique case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               // On a tie the master that was not served last wins.
               gnt_nxt   = (m0_req && m1_req) ? ~last_q : m1_req;
               we_nxt    = gnt_nxt ? m1_we    : m0_we;
               sel_nxt   = gnt_nxt ? m1_sel   : m0_sel;
               addr_nxt  = gnt_nxt ? m1_addr  : m0_addr;
               wdata_nxt = gnt_nxt ? m1_wdata : m0_wdata;
               err_nxt   = !sel_nxt && (addr_nxt[CMD_AW-1:RAM_AW] != '0);
               if (err_nxt) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = ISSUE;
                  last_nxt  = gnt_nxt;
               end
            end
         end
         ISSUE: begin
            cnt_nxt   = '0;
            state_nxt = we_q ? RESP : WAIT;
         end
         WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_nxt   = '0;
               cap       = 1'b1;
               state_nxt = RESP;
            end else begin
               cnt_nxt = cnt_q + 3'd1;
            end
         end
         RESP: state_nxt = IDLE;
      endcase
   end

   // Memory controls are registered from the state being entered.
   assign act     = (state_nxt == ISSUE) || (state_nxt == WAIT);
   assign rw_d    = (state_nxt == WAIT) || !we_nxt;
   assign ram_act = act && !sel_nxt;
   assign cmd_act = act && sel_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_q    <= 1'b1;
         gnt_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_err    <= 1'b0;
         m1_err    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         ram_en    <= 1'b0;
         ram_rw    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         cmd_en    <= 1'b0;
         cmd_rw    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else begin
         state     <= state_nxt;
         last_q    <= last_nxt;
         gnt_q     <= gnt_nxt;
         we_q      <= we_nxt;
         sel_q     <= sel_nxt;
         err_q     <= err_nxt;
         addr_q    <= addr_nxt;
         wdata_q   <= wdata_nxt;
         cnt_q     <= cnt_nxt;
         m0_ack    <= (state_nxt == RESP) && !gnt_nxt;
         m1_ack    <= (state_nxt == RESP) && gnt_nxt;
         m0_err    <= (state_nxt == RESP) && !gnt_nxt && err_nxt;
         m1_err    <= (state_nxt == RESP) && gnt_nxt && err_nxt;
         ram_en    <= ram_act;
         ram_rw    <= ram_act && rw_d;
         ram_addr  <= ram_act ? addr_nxt[RAM_AW-1:0] : '0;
         ram_wdata <= ram_act ? wdata_nxt[RAM_W-1:0] : '0;
         cmd_en    <= cmd_act;
         cmd_rw    <= cmd_act && rw_d;
         cmd_addr  <= cmd_act ? addr_nxt : '0;
         cmd_wdata <= cmd_act ? wdata_nxt : '0;
         if (cap) begin
            if (gnt_q) m1_rdata <= sel_q ? cmd_rdata : ram_ext;
            else       m0_rdata <= sel_q ? cmd_rdata : ram_ext;
         end
      end
   end

endmodule
